// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Issue-side bundle of the scoreboarded register file: read
//                ports, two write ports, destination claim, hazard/busy and
//                stall-counter observation.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNTW  = 16
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   i_rs1;
    logic [AW-1:0]   i_rs2;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            i_wr0_en;
    logic [AW-1:0]   i_wr0_addr;
    logic [XLEN-1:0] i_wr0_data;
    logic            i_wr1_en;
    logic [AW-1:0]   i_wr1_addr;
    logic [XLEN-1:0] i_wr1_data;
    logic            i_claim;
    logic [AW-1:0]   i_claim_rd;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic            o_hazard;
    logic [NREGS-1:0] o_busy_vec;
    logic [CNTW-1:0] o_stall_cnt;

    // Issue logic / pipeline side drives requests and observes status
    modport master (
        output i_rs1, i_rs2, i_wr0_en, i_wr0_addr, i_wr0_data,
               i_wr1_en, i_wr1_addr, i_wr1_data, i_claim, i_claim_rd,
        input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
               o_hazard, o_busy_vec, o_stall_cnt
    );

    // Register file side
    modport slave (
        input  i_rs1, i_rs2, i_wr0_en, i_wr0_addr, i_wr0_data,
               i_wr1_en, i_wr1_addr, i_wr1_data, i_claim, i_claim_rd,
        output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
               o_hazard, o_busy_vec, o_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Two-read / two-write register file with write bypass,
//                per-register busy scoreboard, issue hazard detection and a
//                saturating stall-cycle counter. x0 is hard-wired to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNTW  = 16
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    regfile_sb_if.slave     bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs_q [NREGS];
    logic [XLEN-1:0]  w_regs_d [NREGS];
    logic [NREGS-1:0] r_busy_q;
    logic [NREGS-1:0] w_busy_d;
    logic [CNTW-1:0]  r_stall_cnt_q;
    logic [CNTW-1:0]  w_stall_cnt_d;

    logic             w_wr0_vld;
    logic             w_wr1_vld;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_rs1_wr;
    logic             w_rs2_wr;
    logic             w_claim_wr;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_claim_conflict;
    logic             w_hazard;
    logic             w_claim_accept;

    // Writes to x0 are discarded up front so nothing downstream sees them
    assign w_wr0_vld = bus.i_wr0_en && (bus.i_wr0_addr != '0);
    assign w_wr1_vld = bus.i_wr1_en && (bus.i_wr1_addr != '0);

    // Combinational read ports with same-cycle bypass, port 1 taking priority
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (bus.i_rs1 != '0) begin
            if (w_wr1_vld && (bus.i_wr1_addr == bus.i_rs1))      w_rs1_data = bus.i_wr1_data;
            else if (w_wr0_vld && (bus.i_wr0_addr == bus.i_rs1)) w_rs1_data = bus.i_wr0_data;
            else                                                 w_rs1_data = r_regs_q[bus.i_rs1];
        end
        if (bus.i_rs2 != '0) begin
            if (w_wr1_vld && (bus.i_wr1_addr == bus.i_rs2))      w_rs2_data = bus.i_wr1_data;
            else if (w_wr0_vld && (bus.i_wr0_addr == bus.i_rs2)) w_rs2_data = bus.i_wr0_data;
            else                                                 w_rs2_data = r_regs_q[bus.i_rs2];
        end
    end

    // Hazard detection: a pending write being retired this cycle is not a hazard
    always_comb begin
        w_rs1_wr   = (w_wr0_vld && (bus.i_wr0_addr == bus.i_rs1)) ||
                     (w_wr1_vld && (bus.i_wr1_addr == bus.i_rs1));
        w_rs2_wr   = (w_wr0_vld && (bus.i_wr0_addr == bus.i_rs2)) ||
                     (w_wr1_vld && (bus.i_wr1_addr == bus.i_rs2));
        w_claim_wr = (w_wr0_vld && (bus.i_wr0_addr == bus.i_claim_rd)) ||
                     (w_wr1_vld && (bus.i_wr1_addr == bus.i_claim_rd));
        w_rs1_busy = r_busy_q[bus.i_rs1] && !w_rs1_wr;
        w_rs2_busy = r_busy_q[bus.i_rs2] && !w_rs2_wr;
        w_claim_conflict = bus.i_claim && r_busy_q[bus.i_claim_rd] && !w_claim_wr &&
                           (bus.i_claim_rd != '0);
        w_hazard       = w_rs1_busy || w_rs2_busy || w_claim_conflict;
        w_claim_accept = bus.i_claim && !w_hazard && (bus.i_claim_rd != '0);
    end

    // Next state: register writes (port 1 last so it wins), busy clear then claim set
    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        if (w_wr0_vld) begin
            w_regs_d[bus.i_wr0_addr] = bus.i_wr0_data;
            w_busy_d[bus.i_wr0_addr] = 1'b0;
        end
        if (w_wr1_vld) begin
            w_regs_d[bus.i_wr1_addr] = bus.i_wr1_data;
            w_busy_d[bus.i_wr1_addr] = 1'b0;
        end
        if (w_claim_accept) begin
            w_busy_d[bus.i_claim_rd] = 1'b1;
        end
        w_regs_d[0] = '0;
        w_busy_d[0] = 1'b0;
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_hazard && (r_stall_cnt_q != {CNTW{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset wipes data, scoreboard and counter immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs_q[i] <= '0;
            end
            r_busy_q      <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_regs_q      <= w_regs_d;
            r_busy_q      <= w_busy_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign bus.o_rs1_data  = w_rs1_data;
    assign bus.o_rs2_data  = w_rs2_data;
    assign bus.o_rs1_busy  = w_rs1_busy;
    assign bus.o_rs2_busy  = w_rs2_busy;
    assign bus.o_hazard    = w_hazard;
    assign bus.o_busy_vec  = r_busy_q;
    assign bus.o_stall_cnt = r_stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench for regfile_sb. Expected values
//                are queued when a step is driven and compared once settled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_sb;
    localparam int c_XLEN  = 32;
    localparam int c_NREGS = 32;
    localparam int c_CNTW  = 2;

    localparam int c_RS1D  = 0;
    localparam int c_RS2D  = 1;
    localparam int c_RS1B  = 2;
    localparam int c_RS2B  = 3;
    localparam int c_HAZ   = 4;
    localparam int c_BUSYV = 5;
    localparam int c_CNT   = 6;

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb [$];
    logic [63:0] hold_exp [6];

    regfile_sb_if #(.XLEN(c_XLEN), .NREGS(c_NREGS), .CNTW(c_CNTW)) bus ();

    regfile_sb #(.XLEN(c_XLEN), .NREGS(c_NREGS), .CNTW(c_CNTW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            c_RS1D:  return 64'(bus.o_rs1_data);
            c_RS2D:  return 64'(bus.o_rs2_data);
            c_RS1B:  return 64'(bus.o_rs1_busy);
            c_RS2B:  return 64'(bus.o_rs2_busy);
            c_HAZ:   return 64'(bus.o_hazard);
            c_BUSYV: return 64'(bus.o_busy_vec);
            c_CNT:   return 64'(bus.o_stall_cnt);
            default: return 64'hX;
        endcase
    endfunction

    task automatic expect_val(input int sig, input logic [63:0] val, input string tag);
        exp_t e;
        e.sig = sig;
        e.exp = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $display("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
                $error("check %s", e.tag);
            end
        end
    endtask

    task automatic idle();
        bus.i_rs1      = '0;
        bus.i_rs2      = '0;
        bus.i_wr0_en   = 1'b0;
        bus.i_wr0_addr = '0;
        bus.i_wr0_data = '0;
        bus.i_wr1_en   = 1'b0;
        bus.i_wr1_addr = '0;
        bus.i_wr1_data = '0;
        bus.i_claim    = 1'b0;
        bus.i_claim_rd = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        hold_exp[0] = 64'd1; hold_exp[1] = 64'd2; hold_exp[2] = 64'd3;
        hold_exp[3] = 64'd3; hold_exp[4] = 64'd3; hold_exp[5] = 64'd3;
        rst_n = 1'b0;
        idle();
        bus.i_rs1 = 5'd5;
        #2;
        expect_val(c_CNT,   0, "rst_cnt");
        expect_val(c_BUSYV, 0, "rst_busyv");
        expect_val(c_RS1D,  0, "rst_rs1d");
        expect_val(c_HAZ,   0, "rst_haz");
        check();
        step();
        rst_n = 1'b1;

        // Write x5 on port 0, read it back next cycle
        step();
        bus.i_wr0_en = 1'b1; bus.i_wr0_addr = 5'd5; bus.i_wr0_data = 32'hDEADBEEF;
        #1 check();
        step();
        bus.i_rs1 = 5'd5;
        expect_val(c_RS1D, 64'hDEADBEEF, "x5_read");
        expect_val(c_RS1B, 0, "x5_busy");
        #1 check();

        // Dual write to x7: port 1 wins, both bypassed and stored
        step();
        bus.i_wr0_en = 1'b1; bus.i_wr0_addr = 5'd7; bus.i_wr0_data = 32'h11;
        bus.i_wr1_en = 1'b1; bus.i_wr1_addr = 5'd7; bus.i_wr1_data = 32'h22;
        bus.i_rs2 = 5'd7;
        expect_val(c_RS2D, 64'h22, "x7_bypass");
        #1 check();
        step();
        bus.i_rs2 = 5'd7;
        expect_val(c_RS2D, 64'h22, "x7_stored");
        #1 check();

        // x0 ignores writes and claims
        step();
        bus.i_wr0_en = 1'b1; bus.i_wr0_addr = 5'd0; bus.i_wr0_data = 32'hFFFFFFFF;
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd0;
        expect_val(c_RS1D, 0, "x0_bypass");
        expect_val(c_HAZ,  0, "x0_haz");
        #1 check();
        step();
        expect_val(c_RS1D,  0, "x0_read");
        expect_val(c_BUSYV, 0, "x0_busyv");
        #1 check();

        // Claim x3, stall on it, then retire it through port 1
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd3;
        expect_val(c_HAZ, 0, "claim3_haz");
        #1 check();
        step();
        bus.i_rs1 = 5'd3;
        expect_val(c_RS1B,  1, "x3_busy");
        expect_val(c_HAZ,   1, "x3_haz");
        expect_val(c_CNT,   0, "x3_cnt0");
        expect_val(c_BUSYV, 64'h8, "x3_busyv");
        #1 check();
        step();
        bus.i_rs1 = 5'd3;
        bus.i_wr1_en = 1'b1; bus.i_wr1_addr = 5'd3; bus.i_wr1_data = 32'h9;
        expect_val(c_CNT,  1, "x3_cnt1");
        expect_val(c_RS1B, 0, "x3_wr_busy");
        expect_val(c_RS1D, 64'h9, "x3_wr_data");
        expect_val(c_HAZ,  0, "x3_wr_haz");
        #1 check();
        step();
        bus.i_rs1 = 5'd3;
        expect_val(c_BUSYV, 0, "x3_cleared");
        expect_val(c_RS1D, 64'h9, "x3_stored");
        #1 check();

        // Claim x4, then reclaim while it is being written (claim wins)
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd4;
        #1 check();
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd4;
        bus.i_wr0_en = 1'b1; bus.i_wr0_addr = 5'd4; bus.i_wr0_data = 32'h44;
        bus.i_rs2 = 5'd4;
        expect_val(c_HAZ,  0, "x4_clm_wr_haz");
        expect_val(c_RS2B, 0, "x4_wr_rs2busy");
        expect_val(c_RS2D, 64'h44, "x4_wr_bypass");
        #1 check();
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd4;
        expect_val(c_BUSYV, 64'h10, "x4_claim_wins");
        expect_val(c_HAZ,   1, "x4_reclaim_haz");
        #1 check();
        // Claim of free x6 blocked by a source hazard on x4
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd6;
        bus.i_rs1 = 5'd4;
        expect_val(c_RS1B,  1, "x6_rs1busy");
        expect_val(c_HAZ,   1, "x6_haz");
        expect_val(c_BUSYV, 64'h10, "x4_drop");
        expect_val(c_CNT,   2, "cnt_two");
        #1 check();
        step();
        expect_val(c_BUSYV, 64'h10, "x6_drop");
        expect_val(c_CNT,   3, "cnt_three");
        #1 check();

        // Mid-operation reset with write/claim presented during reset
        step();
        rst_n = 1'b0;
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd2;
        bus.i_wr0_en = 1'b1; bus.i_wr0_addr = 5'd9; bus.i_wr0_data = 32'h99;
        bus.i_rs1 = 5'd4; bus.i_rs2 = 5'd9;
        #1;
        expect_val(c_CNT,   0, "mrst_cnt");
        expect_val(c_BUSYV, 0, "mrst_busyv");
        expect_val(c_RS1D,  0, "mrst_rs1d");
        expect_val(c_RS2D,  64'h99, "mrst_bypass");
        expect_val(c_HAZ,   0, "mrst_haz");
        check();
        step();
        rst_n = 1'b1;
        bus.i_wr1_en = 1'b1; bus.i_wr1_addr = 5'd10; bus.i_wr1_data = 32'hA;
        bus.i_rs1 = 5'd9;
        expect_val(c_RS1D,  0, "mrst_no_wr");
        expect_val(c_BUSYV, 0, "mrst_no_claim");
        #1 check();
        step();
        bus.i_rs1 = 5'd10;
        expect_val(c_RS1D, 64'hA, "first_edge_wr");
        #1 check();

        // Saturating stall counter over six hazard cycles, then async reset
        step();
        bus.i_claim = 1'b1; bus.i_claim_rd = 5'd8;
        #1 check();
        step();
        bus.i_rs1 = 5'd8;
        expect_val(c_HAZ, 1, "x8_haz");
        #1 check();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            expect_val(c_CNT, hold_exp[k], $sformatf("sat_cnt%0d", k));
            check();
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(c_CNT,   0, "arst_cnt");
        expect_val(c_BUSYV, 0, "arst_busyv");
        expect_val(c_RS1B,  0, "arst_rs1busy");
        check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, 2..64; AW = log2(NREGS).
REQ-003 Parameter CNTW, default 16, width of the stall counter.
REQ-004 Port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 Ports i_rs1 / i_rs2, input, AW each, read-port addresses.
REQ-007 Ports o_rs1_data / o_rs2_data, output, XLEN each, read data.
REQ-008 Ports i_wr0_en, i_wr0_addr (AW), i_wr0_data (XLEN), input, write port 0.
REQ-009 Ports i_wr1_en, i_wr1_addr (AW), i_wr1_data (XLEN), input, write port 1; higher priority than port 0.
REQ-010 Ports i_claim (1) and i_claim_rd (AW), input, issue-time destination reservation.
REQ-011 Ports o_rs1_busy / o_rs2_busy, output, 1 each, source register has a pending write.
REQ-012 Port o_hazard, output, 1, issue must stall this cycle.
REQ-013 Port o_busy_vec, output, NREGS, registered busy bits; bit 0 always 0.
REQ-014 Port o_stall_cnt, output, CNTW, saturating count of hazard cycles.

Function
REQ-015 Register 0 SHALL read as 0, ignore writes and never become busy.
REQ-016 Reads SHALL be combinational: o_rsN_data = regs[i_rsN] for nonzero addresses.
REQ-017 Write bypass: if port 1 writes i_rsN (nonzero) this cycle, o_rsN_data SHALL be i_wr1_data; else if port 0 writes it, i_wr0_data.
REQ-018 Writes SHALL commit on the rising edge; same nonzero address on both ports -> port 1 data stored.
REQ-019 A committed write SHALL clear busy[addr] at the same edge.
REQ-020 o_rsN_busy SHALL be busy[i_rsN] AND NOT (either write port writing i_rsN this cycle).
REQ-021 Claim conflict SHALL be i_claim AND busy[i_claim_rd] AND NOT (a write to i_claim_rd this cycle) AND i_claim_rd != 0.
REQ-022 o_hazard SHALL be o_rs1_busy OR o_rs2_busy OR claim conflict, purely combinational.
REQ-023 A claim SHALL set busy[i_claim_rd] at the edge only when i_claim = 1, o_hazard = 0 and i_claim_rd != 0; otherwise it is dropped.
REQ-024 Accepted claim and write to the same register in one cycle: busy SHALL end set (claim wins).
REQ-025 o_stall_cnt SHALL increment by 1 on each edge where o_hazard = 1, saturating at all-ones with no wrap.
REQ-026 Busy bits SHALL never clear except by a write or reset.

Reset
REQ-027 While i_rst_n = 0, asynchronously: all registers 0, o_busy_vec 0, o_stall_cnt 0; read outputs 0 for non-bypassed addresses, busy outputs 0, o_hazard driven only by the current claim and write inputs.
REQ-028 Reset asserted mid-operation SHALL discard all pending claims; writes and claims presented while i_rst_n = 0 SHALL NOT commit.
REQ-029 The first rising edge after i_rst_n rises SHALL process inputs normally.

Verification
REQ-030 Reset, write x5 = 0xDEADBEEF on port 0, next cycle i_rs1 = 5 -> o_rs1_data = 0xDEADBEEF, o_rs1_busy = 0.
REQ-031 Same cycle: port 0 writes x7 = 0x11, port 1 writes x7 = 0x22, i_rs2 = 7 -> o_rs2_data = 0x22 (bypass), and 0x22 the following cycle.
REQ-032 Write x0 = 0xFFFFFFFF with claim x0 -> o_rs1_data = 0 for i_rs1 = 0, o_busy_vec[0] = 0, o_hazard = 0.
REQ-033 Claim x3; next cycle i_rs1 = 3 -> o_rs1_busy = 1, o_hazard = 1, o_stall_cnt 0 -> 1; the cycle after, port 1 writes x3 = 0x9 -> o_rs1_busy = 0, o_rs1_data = 0x9, busy[3] cleared.
REQ-034 busy[4] set; claim x4 while port 0 writes x4 -> claim accepted, busy[4] = 1 after the edge; claim x4 again with no write -> o_hazard = 1, claim dropped.
REQ-035 With CNTW = 2 and hazard held 6 cycles -> o_stall_cnt 1, 2, 3, 3, 3, 3; pull i_rst_n low asynchronously -> o_stall_cnt = 0 and o_busy_vec = 0 before the next edge.
